pipeline_mem_responder: RTL
===========================

Name: pipeline_mem_responder

Overview:
- Memory-side responder for the pipeline memory stage's S_R_*/S_W_* read and write interface; the data-memory model or controller sitting behind the MEM stage.
- Holds a word array and services one read or one write at a time.
- Read and write latencies are programmable.
- Signals completion with S_R_DATA_VALID or S_W_COMPLETE pulses.

Parameters:
- ADDR_WIDTH, 64, byte-address width.
- DATA_WIDTH, 64, word width; fixed at 64 (8 byte lanes).
- MEM_DEPTH, 1024, number of 64-bit words; power of two.
- READ_LATENCY, 2, cycles from read acceptance to data valid; ≥1.
- WRITE_LATENCY, 2, cycles from write acceptance to completion; ≥1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- S_R_ADDR  in  ADDR_WIDTH  read byte address.
- S_R_ADDR_VALID  in  1  read request; initiator holds it until S_R_DATA_VALID.
- S_R_DATA  out  DATA_WIDTH  read data, aligned 64-bit word.
- S_R_DATA_VALID  out  1  one-cycle read response pulse.
- S_W_VALID  in  1  write request.
- S_W_ADDR  in  ADDR_WIDTH  write byte address.
- S_W_DATA  in  DATA_WIDTH  write data, right-justified (LSBs).
- S_W_SIZE  in  2  0=byte, 1=half, 2=word, 3=double.
- S_W_READY  out  1  responder can accept a write.
- S_W_COMPLETE  out  1  one-cycle write-done pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0.
  - S_R_DATA_VALID=0, S_W_COMPLETE=0, S_W_READY=0, S_R_DATA=0.
  - Array contents are not cleared.
  - S_W_READY rises on the first clock edge after release.
- All outputs are registered.
- Word index = addr[log2(MEM_DEPTH)+2:3]. Upper address bits are ignored, so addresses wrap modulo MEM_DEPTH*8.
- States: IDLE, READ_WAIT, READ_RESP, WRITE_WAIT, WRITE_DONE.
- IDLE:
  - S_W_READY=1.
  - If S_W_VALID=1 at an edge: latch addr, data and size; S_W_READY→0; go to WRITE_WAIT with counter=WRITE_LATENCY-1.
  - Else if S_R_ADDR_VALID=1: latch address; go to READ_WAIT with counter=READ_LATENCY-1.
  - A write wins when both requests are present; the read stays pending because the initiator holds its valid.
- READ_WAIT:
  - Decrement the counter each edge.
  - When the counter is 0: load S_R_DATA from the array at the latched index, assert S_R_DATA_VALID, go to READ_RESP.
  - Net effect: the valid pulse is high during the READ_LATENCY-th cycle after the accepting edge.
- READ_RESP:
  - S_R_DATA_VALID is high for exactly this cycle.
  - Next edge: drop S_R_DATA_VALID and go to IDLE.
  - S_R_DATA holds its value until the next read response.
  - S_R_ADDR_VALID is not sampled in this state, so the same request is never double-serviced.
- Read data is the full aligned word; the requester extracts the sub-word using addr[2:0].
- WRITE_WAIT:
  - Count the same way as READ_WAIT.
  - When the counter is 0: perform the array write, assert S_W_COMPLETE, go to WRITE_DONE.
- WRITE_DONE:
  - S_W_COMPLETE is high for this cycle only.
  - Next edge: go to IDLE; S_W_READY returns to 1.
- Write byte lanes:
  - Size s covers 2^s bytes starting at lane addr[2:0].
  - Data byte k goes to lane addr[2:0]+k.
  - Bytes with lane >7 are dropped; writes never cross words.
  - Untouched lanes are preserved via read-modify-write of the word.
- Read-after-write: a read accepted after S_W_COMPLETE sees the new data.
- Read latency is always READ_LATENCY+1 edges from acceptance to return to IDLE; there is no overlap and never more than one outstanding transaction.
- Reset mid-transaction aborts the transaction:
  - A write not yet committed is discarded.
  - No S_R_DATA_VALID or S_W_COMPLETE pulse is emitted.
- S_W_VALID is ignored outside IDLE, where S_W_READY=0.

Test Plan:
- Write then read a double:
  - Write addr 0x40, data 0x1122334455667788, size 3 → S_W_COMPLETE pulses 2 cycles after acceptance, S_W_READY=0 meanwhile.
  - Read 0x40 → S_R_DATA_VALID for one cycle, 2 cycles after acceptance, with data 0x1122334455667788.
- Byte lane write:
  - Word at 0x40 as above; write byte 0xAB to 0x43 → read 0x40 returns 0x11223344AB667788.
- Misaligned truncation:
  - Write half 0xBEEF to 0x47 → only lane 7 becomes 0xEF; read returns 0xEF22…
- Simultaneous requests:
  - S_W_VALID and S_R_ADDR_VALID both high in IDLE, same addr 0x80 → write completes first.
  - The held read is then accepted and returns the new value.
- Reset mid-read and mid-write:
  - Assert reset during READ_WAIT → no S_R_DATA_VALID.
  - Assert reset during WRITE_WAIT → no S_W_COMPLETE and memory unchanged.
  - S_W_READY=1 one edge after reset release.
- Address wrap and latency parameters:
  - With MEM_DEPTH=1024, a write to 0x2040 aliases 0x40.
  - Rerun with READ_LATENCY=1 and WRITE_LATENCY=5 and check pulse timing.

Source files
------------

// File: rtl/pipeline_mem_responder.sv
// pipeline_mem_responder
//   Data-memory model sitting behind the pipeline MEM stage. Holds a word
//   array and services one read or one write at a time, each with its own
//   programmable latency, and reports completion with one-cycle pulses.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   S_R_ADDR       read byte address
//   S_R_ADDR_VALID read request, held by the initiator until S_R_DATA_VALID
//   S_R_DATA       aligned 64-bit read word (held until the next response)
//   S_R_DATA_VALID one-cycle read response pulse
//   S_W_VALID      write request
//   S_W_ADDR       write byte address
//   S_W_DATA       right-justified write data
//   S_W_SIZE       0=byte 1=half 2=word 3=double
//   S_W_READY      high while idle and able to take a write
//   S_W_COMPLETE   one-cycle write-done pulse
module pipeline_mem_responder #(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int MEM_DEPTH     = 1024,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] S_R_ADDR,
  input  logic                  S_R_ADDR_VALID,
  output logic [DATA_WIDTH-1:0] S_R_DATA,
  output logic                  S_R_DATA_VALID,
  input  logic                  S_W_VALID,
  input  logic [ADDR_WIDTH-1:0] S_W_ADDR,
  input  logic [DATA_WIDTH-1:0] S_W_DATA,
  input  logic [1:0]            S_W_SIZE,
  output logic                  S_W_READY,
  output logic                  S_W_COMPLETE
);

  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    READ_RESP,
    WRITE_WAIT,
    WRITE_DONE
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   counter, counter_next;
  logic               count_done;
  logic [IDX_W-1:0]   rd_idx, wr_idx;
  logic [2:0]         wr_lane;
  logic [1:0]         wr_size;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] merged;
  logic [3:0]         wr_nbytes;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Address bits outside the word index are deliberately ignored (aliasing);
  // read offset bits are the requester's business.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_R_ADDR[ADDR_WIDTH-1:IDX_W+3], S_R_ADDR[2:0],
                              S_W_ADDR[ADDR_WIDTH-1:IDX_W+3]};

  assign count_done = (counter == '0);

  always_comb begin
    state_next   = state;
    counter_next = counter;
    case (state)
      IDLE: begin
        // Writes take priority; a concurrent read stays pending because
        // its initiator keeps the valid asserted.
        if (S_W_VALID) begin
          state_next   = WRITE_WAIT;
          counter_next = CNT_W'(WRITE_LATENCY - 1);
        end else if (S_R_ADDR_VALID) begin
          state_next   = READ_WAIT;
          counter_next = CNT_W'(READ_LATENCY - 1);
        end
      end
      READ_WAIT: begin
        if (count_done) state_next = READ_RESP;
        else            counter_next = counter - CNT_W'(1);
      end
      READ_RESP:  state_next = IDLE;
      WRITE_WAIT: begin
        if (count_done) state_next = WRITE_DONE;
        else            counter_next = counter - CNT_W'(1);
      end
      WRITE_DONE: state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Merge the sized write into the current word; lanes past 7 are dropped
  // so a write never spills into the neighbouring word.
  always_comb begin
    merged    = mem[wr_idx];
    wr_nbytes = 4'd1 << wr_size;
    for (int k = 0; k < 8; k++) begin
      if ((k < int'(wr_nbytes)) && ((int'(wr_lane) + k) < 8)) begin
        merged[(int'(wr_lane) + k)*8 +: 8] = wr_data[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      counter        <= '0;
      rd_idx         <= '0;
      wr_idx         <= '0;
      wr_lane        <= '0;
      wr_size        <= '0;
      wr_data        <= '0;
      S_R_DATA       <= '0;
      S_R_DATA_VALID <= 1'b0;
      S_W_COMPLETE   <= 1'b0;
      S_W_READY      <= 1'b0;
    end else begin
      state          <= state_next;
      counter        <= counter_next;
      S_R_DATA_VALID <= (state == READ_WAIT) && count_done;
      S_W_COMPLETE   <= (state == WRITE_WAIT) && count_done;
      S_W_READY      <= (state_next == IDLE);
      if (state == IDLE) begin
        if (S_W_VALID) begin
          wr_idx  <= S_W_ADDR[IDX_W+2:3];
          wr_lane <= S_W_ADDR[2:0];
          wr_size <= S_W_SIZE;
          wr_data <= S_W_DATA;
        end else if (S_R_ADDR_VALID) begin
          rd_idx <= S_R_ADDR[IDX_W+2:3];
        end
      end
      if ((state == READ_WAIT) && count_done) begin
        S_R_DATA <= mem[rd_idx];
      end
    end
  end

  // The array is never reset; an aborted write cannot commit because reset
  // forces the state out of WRITE_WAIT.
  always_ff @(posedge clk) begin
    if ((state == WRITE_WAIT) && count_done) begin
      mem[wr_idx] <= merged;
    end
  end

endmodule
